asic_sprite_ram_port: RTL and testbench
=======================================

Name: asic_sprite_ram_port

Overview:
- CPU-side writer and video-side reader for the Plus/GX4000 ASIC sprite pattern memory.
- Capacity: 16 sprites × 16 rows × 16 pixels = 4096 four-bit pixels.
- CPU accesses decode at 0x4000–0x4FFF while the ASIC register page is enabled.
- The sprite renderer requests whole 16-pixel rows and receives them as one packed word.
- A single-port synchronous RAM is shared through a small arbitration FSM. After reset, a clear sequence zeroes the RAM.

Parameters:
- BASE_NIB, 4'h4, value of cpu_addr[15:12] that selects sprite RAM.
- CLR_VAL, 4'h0, pixel value written by the clear sequence.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- plus_mode  in  1  Plus/GX4000 features enabled
- page_en  in  1  ASIC register page mapped in
- cpu_addr  in  16  CPU address
- cpu_data  in  8  CPU write data; only [3:0] is stored
- cpu_wr  in  1  single-cycle write strobe
- cpu_rd  in  1  single-cycle read strobe
- cpu_dout  out  8  readback data, {4'h0, pixel}
- cpu_dout_valid  out  1  one-cycle pulse when cpu_dout is valid
- cpu_busy  out  1  a CPU operation is pending or executing, or clear is running
- overrun  out  1  sticky; a decoded CPU access was dropped while busy
- ovr_clr  in  1  clears overrun
- vid_req  in  1  row fetch request, level; held until vid_valid
- vid_sprite  in  4  sprite index for the fetch
- vid_rowsel  in  4  row index for the fetch
- vid_row  out  64  fetched row; pixel c occupies bits [4c+3:4c]
- vid_valid  out  1  one-cycle pulse when vid_row is complete
- ready  out  1  high once the clear sequence is complete

Behaviour:
- Decode: hit = plus_mode & page_en & (cpu_addr[15:12]==BASE_NIB). RAM index = cpu_addr[11:0], split as sprite[11:8], row[7:4], col[3:0]. Strobes without a hit are ignored.
- Reset values:
  - cpu_dout=0, cpu_dout_valid=0, vid_row=0, vid_valid=0, overrun=0, ready=0, cpu_busy=1.
  - FSM enters CLEAR with clear counter = 0. The pending CPU slot is emptied.
- CLEAR state:
  - Writes CLR_VAL to index counter each cycle, for 4096 cycles.
  - After index 4095, the next cycle sets ready=1 and enters IDLE.
  - Decoded CPU accesses during CLEAR are dropped silently; overrun is not set.
  - vid_req is not serviced and vid_valid stays 0.
- CPU pending slot (one entry: op, index, data):
  - A decoded strobe while the slot is empty and ready=1 loads the slot.
  - A decoded strobe while the slot is full, or while a CPU op is executing, is dropped and sets overrun.
  - Simultaneous cpu_wr and cpu_rd: the write wins and the read is discarded without setting overrun.
  - cpu_busy = ~ready | slot full | state==CPU.
- IDLE arbitration, evaluated each cycle with fixed priority:
  - vid_req → FETCH
  - else slot full → CPU
  - else stay in IDLE.
- FETCH state:
  - Latches vid_sprite and vid_rowsel on entry.
  - Issues 16 RAM reads, col 0..15, one per cycle.
  - RAM read latency is 1 cycle. Each returned nibble is shifted into vid_row at position col.
  - vid_valid pulses on the cycle after the last data returns. If vid_req enters IDLE at cycle N, vid_valid asserts at cycle N+18.
  - vid_row holds its value until the next fetch completes. The FSM then returns to IDLE.
  - CPU strobes arriving during FETCH may still load an empty slot.
- CPU state:
  - Write: RAM written in one cycle; the slot empties; return to IDLE. Total: 1 cycle in CPU.
  - Read: address issued in the CPU cycle; data is captured the next cycle. cpu_dout={4'h0, q} and cpu_dout_valid pulses 2 cycles after the state enters CPU. The slot then empties and the FSM returns to IDLE.
  - cpu_dout holds its value between reads.
- Starvation bound: a pending CPU op runs within at most one FETCH (18 cycles) after it is loaded. A vid_req held across the CPU op is serviced immediately after it.
- Overrun: ovr_clr clears it. If a new overrun event and ovr_clr occur in the same cycle, overrun stays set.
- Reset mid-operation: an in-flight fetch is aborted with no vid_valid. A pending CPU op is discarded. Clear restarts from index 0.
- plus_mode or page_en deasserting: only affects decode of new strobes. An op already in the slot completes.

Test Plan:
- Reset, then idle: ready rises exactly 4097 cycles after reset deasserts. A read of 0x4123 then returns cpu_dout=0x00 with cpu_dout_valid 2 cycles after FSM entry.
- Write 0x4A37←0xF9, then read 0x4A37 → cpu_dout=0x09. An upper-nibble write 0x90 to the same address reads back 0x00.
- Write cols 0..15 of sprite 2, row 5, with values c^4'hA, then assert vid_req with sprite 2, row 5 → vid_valid at N+18 and vid_row=64'h5476_1032_DCFE_98BA.
- vid_req and a CPU write pending in the same IDLE cycle → fetch first. The write completes on the cycle after vid_valid, and cpu_busy falls then.
- Two decoded writes 1 cycle apart during FETCH → first is retained, second is dropped, overrun=1. ovr_clr → overrun=0.
- Assert reset on the 8th cycle of a FETCH → no vid_valid pulse, ready=0, the clear sequence restarts, and a previously written pixel reads back 0x00 afterwards.

Source files
------------

// File: rtl/asic_sprite_ram_port.sv
`default_nettype none
// ============================================================================
// Module   : asic_sprite_ram_port
// Brief    : Plus/GX4000 sprite pattern RAM, CPU writer/reader + video row fetch
// Revision : 1.0 - initial release
// ============================================================================
module asic_sprite_ram_port #(
    parameter logic [3:0] BASE_NIB = 4'h4,
    parameter logic [3:0] CLR_VAL  = 4'h0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        plus_mode,
    input  logic        page_en,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    output logic [7:0]  cpu_dout,
    output logic        cpu_dout_valid,
    output logic        cpu_busy,
    output logic        overrun,
    input  logic        ovr_clr,
    input  logic        vid_req,
    input  logic [3:0]  vid_sprite,
    input  logic [3:0]  vid_rowsel,
    output logic [63:0] vid_row,
    output logic        vid_valid,
    output logic        ready
);

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;
    localparam logic [1:0] S_CPU   = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [12:0] r_clr_cnt;
    logic [4:0]  r_fcnt;
    logic [3:0]  r_spr;
    logic [3:0]  r_row;
    logic [59:0] r_acc;
    logic        r_cpu_ph;
    logic        r_slot_full;
    logic        r_slot_wr;
    logic [11:0] r_slot_idx;
    logic [3:0]  r_slot_dat;
    logic [3:0]  r_mem [0:4095];
    logic [3:0]  r_q;

    logic        w_hit;
    logic        w_strobe;
    logic        w_load;
    logic        w_ovr;
    logic        w_we;
    logic [11:0] w_addr;
    logic [3:0]  w_wd;
    logic [3:0]  w_cap_col;
    logic        w_unused_ok;

    assign w_hit       = plus_mode & page_en & (cpu_addr[15:12] == BASE_NIB);
    assign w_strobe    = w_hit & (cpu_wr | cpu_rd);
    assign w_load      = w_strobe & ready & ~r_slot_full;
    assign w_ovr       = w_strobe & ready & r_slot_full;
    assign w_cap_col   = r_fcnt[3:0] - 4'd1;
    assign cpu_busy    = ~ready | r_slot_full | (r_state == S_CPU);
    assign w_unused_ok = &{1'b0, cpu_data[7:4]};

    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= S_CLEAR;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR: if (r_clr_cnt[12]) w_next = S_IDLE;
            S_IDLE: begin
                if (vid_req)          w_next = S_FETCH;
                else if (r_slot_full) w_next = S_CPU;
            end
            S_FETCH: if (r_fcnt == 5'd16) w_next = S_IDLE;
            S_CPU:   if (r_slot_wr | r_cpu_ph) w_next = S_IDLE;
            default: w_next = S_CLEAR;
        endcase
    end

    // RAM port control: clear writes, fetch reads, or the pending CPU op
    always_comb begin
        w_we   = 1'b0;
        w_addr = 12'h000;
        w_wd   = CLR_VAL;
        case (r_state)
            S_CLEAR: begin
                w_addr = r_clr_cnt[11:0];
                w_we   = ~r_clr_cnt[12];
            end
            S_FETCH: w_addr = {r_spr, r_row, r_fcnt[3:0]};
            S_CPU: begin
                w_addr = r_slot_idx;
                w_we   = r_slot_wr & r_slot_full;
                w_wd   = r_slot_dat;
            end
            default: w_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (w_we) r_mem[w_addr] <= w_wd;
        r_q <= r_mem[w_addr];
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clr_cnt      <= 13'd0;
            r_fcnt         <= 5'd0;
            r_cpu_ph       <= 1'b0;
            r_slot_full    <= 1'b0;
            ready          <= 1'b0;
            overrun        <= 1'b0;
            cpu_dout       <= 8'h00;
            cpu_dout_valid <= 1'b0;
            vid_row        <= 64'h0;
            vid_valid      <= 1'b0;
        end else begin
            cpu_dout_valid <= 1'b0;
            vid_valid      <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    if (r_clr_cnt[12]) ready     <= 1'b1;
                    else               r_clr_cnt <= r_clr_cnt + 13'd1;
                end
                S_IDLE: begin
                    r_fcnt   <= 5'd0;
                    r_cpu_ph <= 1'b0;
                end
                S_FETCH: begin
                    r_fcnt <= r_fcnt + 5'd1;
                    if (r_fcnt == 5'd16) begin
                        vid_row   <= {r_q, r_acc};
                        vid_valid <= 1'b1;
                    end
                end
                S_CPU: begin
                    if (r_slot_wr) begin
                        r_slot_full <= 1'b0;
                    end else if (!r_cpu_ph) begin
                        r_cpu_ph <= 1'b1;
                    end else begin
                        cpu_dout       <= {4'h0, r_q};
                        cpu_dout_valid <= 1'b1;
                        r_slot_full    <= 1'b0;
                    end
                end
                default: r_fcnt <= 5'd0;
            endcase
            if (w_load) r_slot_full <= 1'b1;
            // A fresh overrun event takes precedence over a clear request
            if (w_ovr)        overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (r_state == S_IDLE && w_next == S_FETCH) begin
            r_spr <= vid_sprite;
            r_row <= vid_rowsel;
        end
        if (r_state == S_FETCH && r_fcnt != 5'd0 && !r_fcnt[4])
            r_acc[{w_cap_col, 2'b00} +: 4] <= r_q;
        if (w_load) begin
            r_slot_wr  <= cpu_wr;
            r_slot_idx <= cpu_addr[11:0];
            r_slot_dat <= cpu_data[3:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_asic_sprite_ram_port.sv
`default_nettype none
// Directed bench for asic_sprite_ram_port: CPU vector table plus fetch,
// arbitration, overrun and mid-fetch reset sequences.
module tb_asic_sprite_ram_port;

    logic        clk_sys = 1'b0;
    logic        reset, plus_mode, page_en, cpu_wr, cpu_rd, ovr_clr, vid_req;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data, cpu_dout;
    logic [3:0]  vid_sprite, vid_rowsel;
    logic        cpu_dout_valid, cpu_busy, overrun, vid_valid, ready;
    logic [63:0] vid_row;

    always #5 clk_sys = ~clk_sys;

    asic_sprite_ram_port dut (
        .clk_sys(clk_sys), .reset(reset), .plus_mode(plus_mode), .page_en(page_en),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_dout(cpu_dout), .cpu_dout_valid(cpu_dout_valid), .cpu_busy(cpu_busy),
        .overrun(overrun), .ovr_clr(ovr_clr), .vid_req(vid_req),
        .vid_sprite(vid_sprite), .vid_rowsel(vid_rowsel), .vid_row(vid_row),
        .vid_valid(vid_valid), .ready(ready)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic        pm;
        logic        pe;
        logic [15:0] addr;
        logic [7:0]  din;
        logic        exp_v;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t        tbl[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [63:0] exp_row;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_sys);
    endtask

    // One CPU strobe, then follow it until the port is no longer busy
    task automatic cpu_access(input logic wr, input logic rd, input logic [15:0] a,
                              input logic [7:0] d, output logic seen,
                              output logic [7:0] dout, output int lat);
        logic done;
        cpu_wr = wr; cpu_rd = rd; cpu_addr = a; cpu_data = d;
        cyc();
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        seen = 1'b0; dout = 8'h00; lat = -1; done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cpu_dout_valid) begin
                seen = 1'b1; dout = cpu_dout; lat = i;
            end
            if (!cpu_busy) begin
                done = 1'b1;
                break;
            end
            cyc();
        end
        if (!done) chk("cpu_busy_timeout", 1'b1, 1'b0);
    endtask

    task automatic read_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        logic seen; logic [7:0] dout; int lat;
        cpu_access(1'b0, 1'b1, a, 8'h00, seen, dout, lat);
        chk({name, "_valid"}, seen, 1'b1);
        chk({name, "_dout"}, dout, exp);
    endtask

    task automatic write_op(input logic [15:0] a, input logic [7:0] d);
        logic seen; logic [7:0] dout; int lat;
        cpu_access(1'b1, 1'b0, a, d, seen, dout, lat);
    endtask

    task automatic wait_ready(output int n, output logic saw_vv);
        n = 0; saw_vv = 1'b0;
        while (!ready && n < 5000) begin
            cyc();
            n++;
            if (vid_valid) saw_vv = 1'b1;
        end
    endtask

    task automatic wait_vid(output int k);
        k = 0;
        while (!vid_valid && k < 40) begin
            cyc();
            k++;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (cpu_busy && k < 40) begin
            cyc();
            k++;
        end
        chk("idle_wait", cpu_busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic        seen, saw_vv;
        logic [7:0]  dout;
        int          lat, n, k;

        reset = 1'b1; plus_mode = 1'b1; page_en = 1'b1; cpu_wr = 1'b0; cpu_rd = 1'b0;
        ovr_clr = 1'b0; vid_req = 1'b0; cpu_addr = 16'h0; cpu_data = 8'h0;
        vid_sprite = 4'h0; vid_rowsel = 4'h0;

        for (int c = 0; c < 16; c++) exp_row[4*c +: 4] = 4'(c) ^ 4'hA;

        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 16'h4A37, 8'hF9, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 16'h4A37, 8'h00, 1'b1, 8'h09});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 16'h4A37, 8'h90, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 16'h4A37, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 16'h4000, 8'h07, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 16'h4FFF, 8'h0C, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 16'h4000, 8'h00, 1'b1, 8'h07});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 16'h4FFF, 8'h00, 1'b1, 8'h0C});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 16'h5000, 8'h03, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 16'h3FFF, 8'h00, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h4000, 8'h01, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 16'h4000, 8'h00, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 16'h4000, 8'h00, 1'b1, 8'h07});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 16'h4010, 8'h0B, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 16'h4010, 8'h00, 1'b1, 8'h0B});

        // Reset values and clear sequence; CPU/video activity during clear is ignored
        repeat (3) cyc();
        chk("rst_cpu_dout", cpu_dout, 8'h00);
        chk("rst_dout_valid", cpu_dout_valid, 1'b0);
        chk("rst_vid_row", vid_row, 64'h0);
        chk("rst_vid_valid", vid_valid, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_busy", cpu_busy, 1'b1);
        reset = 1'b0;
        n = 0; saw_vv = 1'b0;
        while (!ready && n < 5000) begin
            cyc();
            n++;
            if (vid_valid) saw_vv = 1'b1;
            cpu_wr = (n == 10);
            cpu_addr = 16'h4123; cpu_data = 8'h05;
            vid_req = (n >= 20 && n < 30);
        end
        cpu_wr = 1'b0;
        chk("ready_latency", n, 4097);
        chk("clear_no_vid_valid", saw_vv, 1'b0);
        chk("clear_no_overrun", overrun, 1'b0);
        chk("busy_after_ready", cpu_busy, 1'b0);

        cpu_access(1'b0, 1'b1, 16'h4123, 8'h00, seen, dout, lat);
        chk("first_rd_valid", seen, 1'b1);
        chk("first_rd_dout", dout, 8'h00);
        chk("first_rd_latency", lat, 3);

        foreach (tbl[i]) begin
            plus_mode = tbl[i].pm; page_en = tbl[i].pe;
            cpu_access(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].din, seen, dout, lat);
            plus_mode = 1'b1; page_en = 1'b1;
            chk($sformatf("vec%0d_valid", i), seen, tbl[i].exp_v);
            if (tbl[i].exp_v) begin
                chk($sformatf("vec%0d_dout", i), dout, tbl[i].exp_dout);
                chk($sformatf("vec%0d_latency", i), lat, 3);
            end
        end
        chk("table_no_overrun", overrun, 1'b0);

        // Row fetch of sprite 2 row 5
        for (int c = 0; c < 16; c++) write_op(16'h4250 + 16'(c), 8'(c) ^ 8'h0A);
        vid_sprite = 4'h2; vid_rowsel = 4'h5; vid_req = 1'b1;
        wait_vid(k);
        vid_req = 1'b0;
        chk("fetch_latency", k, 18);
        chk("fetch_row", vid_row, 64'h5476_1032_DCFE_98BA);
        chk("fetch_row_model", vid_row, exp_row);
        cyc();
        chk("fetch_valid_pulse", vid_valid, 1'b0);
        chk("fetch_row_hold", vid_row, 64'h5476_1032_DCFE_98BA);

        // Pending write and video request in the same IDLE cycle: fetch first
        cpu_wr = 1'b1; cpu_addr = 16'h4777; cpu_data = 8'h06;
        cyc();
        cpu_wr = 1'b0; vid_req = 1'b1;
        wait_vid(k);
        vid_req = 1'b0;
        chk("arb_fetch_latency", k, 18);
        chk("arb_busy_at_valid", cpu_busy, 1'b1);
        cyc(); cyc();
        chk("arb_busy_fell", cpu_busy, 1'b0);
        read_chk("arb_rd", 16'h4777, 8'h06);

        // Two writes on consecutive cycles during a fetch
        vid_req = 1'b1;
        repeat (3) cyc();
        cpu_wr = 1'b1; cpu_addr = 16'h4300; cpu_data = 8'h01;
        cyc();
        cpu_addr = 16'h4301; cpu_data = 8'h02;
        cyc();
        cpu_wr = 1'b0;
        chk("ovr_set", overrun, 1'b1);
        wait_vid(k);
        vid_req = 1'b0;
        chk("ovr_fetch_done", vid_valid, 1'b1);
        wait_idle();
        read_chk("ovr_first_kept", 16'h4300, 8'h01);
        read_chk("ovr_second_dropped", 16'h4301, 8'h00);
        chk("ovr_sticky", overrun, 1'b1);
        ovr_clr = 1'b1;
        cyc();
        ovr_clr = 1'b0;
        chk("ovr_cleared", overrun, 1'b0);

        // New overrun event coinciding with ovr_clr keeps the flag set
        cpu_wr = 1'b1; cpu_addr = 16'h4302; cpu_data = 8'h03;
        cyc();
        cpu_addr = 16'h4303; cpu_data = 8'h04; ovr_clr = 1'b1;
        cyc();
        cpu_wr = 1'b0; ovr_clr = 1'b0;
        chk("ovr_set_beats_clr", overrun, 1'b1);
        wait_idle();
        ovr_clr = 1'b1;
        cyc();
        ovr_clr = 1'b0;
        chk("ovr_cleared2", overrun, 1'b0);

        // Reset on the 8th FETCH cycle
        write_op(16'h4555, 8'h0A);
        read_chk("pre_rst_rd", 16'h4555, 8'h0A);
        vid_req = 1'b1;
        saw_vv = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            cyc();
            if (vid_valid) saw_vv = 1'b1;
        end
        reset = 1'b1; vid_req = 1'b0;
        cyc(); cyc();
        chk("midrst_vid_row", vid_row, 64'h0);
        reset = 1'b0;
        cyc();
        chk("midrst_ready_low", ready, 1'b0);
        chk("midrst_busy", cpu_busy, 1'b1);
        wait_ready(n, seen);
        chk("midrst_no_vid_valid", saw_vv | seen, 1'b0);
        chk("midrst_ready_latency", n + 1, 4097);
        read_chk("midrst_rd_cleared", 16'h4555, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
